// File: rtl/pe_bus_responder_pkg.sv
// Shared types and default constants for the PE bus responder.
// Imported by the interface, the register file and the top level.
package pe_bus_responder_pkg;

    localparam int DATA_W_DEF      = 32;
    localparam int REG_COUNT_DEF   = 32;
    localparam int MEM_DEPTH_DEF   = 256;
    localparam int MEM_LATENCY_DEF = 2;
    localparam int REG_IDX_W       = 5;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OPERAND,
        ST_MEM_WAIT,
        ST_MEM_ACK
    } bus_state_e;

    // Width of a down-counter that must hold latency-1.
    function automatic int lat_cnt_w(input int lat);
        return (lat < 3) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/pe_bus_responder_if.sv
// Operand / memory bus between a processing element (master) and its responder (slave).
interface pe_bus_responder_if
    import pe_bus_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                 reg_select;
    logic [REG_IDX_W-1:0] rs1Out;
    logic [REG_IDX_W-1:0] rs2Out;
    logic                 rdWrite;
    logic [REG_IDX_W-1:0] rdOut;
    logic [DATA_W-1:0]    result_out;
    logic                 mem_read;
    logic                 mem_write;
    logic [DATA_W-1:0]    mem_address;
    logic [DATA_W-1:0]    messReg;
    logic [DATA_W-1:0]    AmuxIn;
    logic [DATA_W-1:0]    BmuxIn;
    logic                 data_Ready;
    logic                 mem_ack;
    logic                 bus_err;

    modport master (
        output reg_select, rs1Out, rs2Out, rdWrite, rdOut, result_out,
               mem_read, mem_write, mem_address, messReg,
        input  AmuxIn, BmuxIn, data_Ready, mem_ack, bus_err
    );

    modport slave (
        input  reg_select, rs1Out, rs2Out, rdWrite, rdOut, result_out,
               mem_read, mem_write, mem_address, messReg,
        output AmuxIn, BmuxIn, data_Ready, mem_ack, bus_err
    );

endinterface

// File: rtl/pe_bus_responder_regfile.sv
// Architectural register file: two combinational read ports with write-to-read
// bypass, one write port, x0 hard-wired to zero, synchronous clear on reset.
module pe_regfile
    import pe_bus_responder_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REG_COUNT = REG_COUNT_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [REG_IDX_W-1:0] wa,
    input  logic [DATA_W-1:0]    wd,
    input  logic [REG_IDX_W-1:0] ra1,
    input  logic [REG_IDX_W-1:0] ra2,
    output logic [DATA_W-1:0]    rd1,
    output logic [DATA_W-1:0]    rd2
);

    logic [DATA_W-1:0] regs_reg [1:REG_COUNT-1];

    genvar gi;
    generate
        for (gi = 1; gi < REG_COUNT; gi++) begin : g_reg
            always_ff @(posedge clk) begin
                if (reset) begin
                    regs_reg[gi] <= '0;
                end else if (we && (wa == REG_IDX_W'(gi))) begin
                    regs_reg[gi] <= wd;
                end
            end
        end
    endgenerate

    // A write in flight this cycle is visible to a same-cycle read of that index.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if ((ra1 != '0) && (int'(ra1) < REG_COUNT)) begin
            rd1 = (we && (wa == ra1)) ? wd : regs_reg[ra1];
        end
        if ((ra2 != '0) && (int'(ra2) < REG_COUNT)) begin
            rd2 = (we && (wa == ra2)) ? wd : regs_reg[ra2];
        end
    end

endmodule

// File: rtl/pe_bus_responder.sv
// Responder end of the PE operand/memory bus: register file, data memory, bus FSM.
// Optional address bounds checking is enabled with `define MEM_BOUNDS_CHECK_EN.
module pe_bus_responder
    import pe_bus_responder_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int REG_COUNT   = REG_COUNT_DEF,
    parameter int MEM_DEPTH   = MEM_DEPTH_DEF,
    parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    pe_bus_responder_if.slave bus
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = lat_cnt_w(MEM_LATENCY);

    bus_state_e          state_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic [IDX_W-1:0]    addr_idx_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic                is_store_reg;
    logic [DATA_W-1:0]   amux_reg;
    logic [DATA_W-1:0]   bmux_reg;
    logic                data_ready_reg;
    logic                mem_ack_reg;
    logic [DATA_W-1:0]   rf_rd1;
    logic [DATA_W-1:0]   rf_rd2;
    logic                in_range;
    logic                mem_fire;
    logic                mem_we;

    logic [DATA_W-1:0]   mem_arr [MEM_DEPTH];

`ifdef MEM_BOUNDS_CHECK_EN
    logic oob_reg;
    logic bus_err_reg;
    assign in_range    = !oob_reg;
    assign bus.bus_err = bus_err_reg;
`else
    assign in_range    = 1'b1;
    assign bus.bus_err = 1'b0;
`endif

    pe_regfile #(
        .DATA_W   (DATA_W),
        .REG_COUNT(REG_COUNT)
    ) u_regfile (
        .clk  (clk),
        .reset(reset),
        .we   (bus.rdWrite),
        .wa   (bus.rdOut),
        .wd   (bus.result_out),
        .ra1  (bus.rs1Out),
        .ra2  (bus.rs2Out),
        .rd1  (rf_rd1),
        .rd2  (rf_rd2)
    );

    // The access completes on the edge that moves MEM_WAIT to MEM_ACK; reset on that
    // edge aborts it, so the store enable is gated by reset.
    assign mem_fire = (state_reg == ST_MEM_WAIT) && (cnt_reg == '0);
    assign mem_we   = mem_fire && is_store_reg && in_range && !reset;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_arr[addr_idx_reg] <= wdata_reg;
        end
    end

    // Counter is loaded with MEM_LATENCY-1 and MEM_WAIT dwells until it reaches zero,
    // so mem_ack rises MEM_LATENCY edges after the request is sampled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            addr_idx_reg   <= '0;
            wdata_reg      <= '0;
            is_store_reg   <= 1'b0;
            amux_reg       <= '0;
            bmux_reg       <= '0;
            data_ready_reg <= 1'b0;
            mem_ack_reg    <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
            oob_reg        <= 1'b0;
            bus_err_reg    <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.mem_write || bus.mem_read) begin
                        addr_idx_reg <= bus.mem_address[IDX_W+1:2];
                        wdata_reg    <= bus.messReg;
                        is_store_reg <= bus.mem_write;
                        cnt_reg      <= CNT_W'(MEM_LATENCY - 1);
`ifdef MEM_BOUNDS_CHECK_EN
                        oob_reg      <= (bus.mem_address >= DATA_W'(4 * MEM_DEPTH));
`endif
                        state_reg    <= ST_MEM_WAIT;
                    end else if (bus.reg_select) begin
                        amux_reg       <= rf_rd1;
                        bmux_reg       <= rf_rd2;
                        data_ready_reg <= 1'b1;
                        state_reg      <= ST_OPERAND;
                    end
                end
                ST_OPERAND: begin
                    if (bus.reg_select) begin
                        amux_reg       <= rf_rd1;
                        bmux_reg       <= rf_rd2;
                        data_ready_reg <= 1'b1;
                    end else begin
                        data_ready_reg <= 1'b0;
                        state_reg      <= ST_IDLE;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_fire) begin
                        if (!is_store_reg) begin
                            amux_reg <= in_range ? mem_arr[addr_idx_reg] : '0;
                        end
`ifdef MEM_BOUNDS_CHECK_EN
                        bus_err_reg <= oob_reg;
`endif
                        mem_ack_reg <= 1'b1;
                        state_reg   <= ST_MEM_ACK;
                    end else begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end
                ST_MEM_ACK: begin
                    if (!(bus.mem_read || bus.mem_write)) begin
                        mem_ack_reg <= 1'b0;
`ifdef MEM_BOUNDS_CHECK_EN
                        bus_err_reg <= 1'b0;
`endif
                        state_reg   <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.AmuxIn     = amux_reg;
    assign bus.BmuxIn     = bmux_reg;
    assign bus.data_Ready = data_ready_reg;
    assign bus.mem_ack    = mem_ack_reg;

endmodule

// File: tb/tb_pe_bus_responder.sv
// Randomized scoreboard bench for pe_bus_responder against a register/memory array model.
// Honours `define MEM_BOUNDS_CHECK_EN in its expectations.
module tb_pe_bus_responder;
    import pe_bus_responder_pkg::*;

    localparam int DATA_W      = 32;
    localparam int MEM_DEPTH   = 256;
    localparam int MEM_LATENCY = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    pe_bus_responder_if #(.DATA_W(DATA_W)) bus ();

    pe_bus_responder #(
        .DATA_W     (DATA_W),
        .REG_COUNT  (32),
        .MEM_DEPTH  (MEM_DEPTH),
        .MEM_LATENCY(MEM_LATENCY)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
    } op_exp_t;

    typedef struct {
        bit          is_load;
        bit          chk;
        logic [31:0] data;
        logic        err;
    } mem_exp_t;

    op_exp_t  op_q[$];
    mem_exp_t mem_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] model_r  [32];
    logic [31:0] model_m  [MEM_DEPTH];
    bit          model_mv [MEM_DEPTH];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_model(input int idx);
        return (idx == 0) ? 32'h0 : model_r[idx];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.reg_select  = 1'b0;
        bus.rs1Out      = '0;
        bus.rs2Out      = '0;
        bus.rdWrite     = 1'b0;
        bus.rdOut       = '0;
        bus.result_out  = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_address = '0;
        bus.messReg     = '0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic     prev_ack = 1'b0;
    op_exp_t  mon_op;
    mem_exp_t mon_mem;
    int       n_txn = 0;

    always @(negedge clk) begin
        if (bus.data_Ready === 1'b1) begin
            if (op_q.size() == 0) begin
                check("unexpected data_Ready", 32'(bus.data_Ready), 32'h0);
            end else begin
                mon_op = op_q.pop_front();
                check("operand A", bus.AmuxIn, mon_op.a);
                check("operand B", bus.BmuxIn, mon_op.b);
                n_txn++;
                $display("txn %0d operand A=0x%08h B=0x%08h", n_txn, bus.AmuxIn, bus.BmuxIn);
            end
        end
        if (bus.mem_ack === 1'b1 && prev_ack !== 1'b1) begin
            if (mem_q.size() == 0) begin
                check("unexpected mem_ack", 32'(bus.mem_ack), 32'h0);
            end else begin
                mon_mem = mem_q.pop_front();
                if (mon_mem.is_load && mon_mem.chk) begin
                    check("load data", bus.AmuxIn, mon_mem.data);
                end
                check("bus_err with ack", 32'(bus.bus_err), 32'(mon_mem.err));
                n_txn++;
                $display("txn %0d %s ack data=0x%08h err=%0b", n_txn,
                         mon_mem.is_load ? "load" : "store", bus.AmuxIn, bus.bus_err);
            end
        end
        prev_ack = bus.mem_ack;
    end

    // ---------------- stimulus tasks ----------------
    task automatic op_cycle(input logic [4:0] rs1, input logic [4:0] rs2, input bit we,
                            input logic [4:0] rd, input logic [31:0] data);
        op_exp_t e;
        bus.reg_select = 1'b1;
        bus.rs1Out     = rs1;
        bus.rs2Out     = rs2;
        bus.rdWrite    = we;
        bus.rdOut      = rd;
        bus.result_out = data;
        if (we && rd != 0) model_r[rd] = data;
        e.a = rd_model(int'(rs1));
        e.b = rd_model(int'(rs2));
        op_q.push_back(e);
        tick();
    endtask

    task automatic op_end();
        bus.reg_select = 1'b0;
        bus.rdWrite    = 1'b0;
        tick();
        check("data_Ready drop", 32'(bus.data_Ready), 32'h0);
    endtask

    task automatic wb_idle(input logic [4:0] rd, input logic [31:0] data);
        bus.rdWrite    = 1'b1;
        bus.rdOut      = rd;
        bus.result_out = data;
        if (rd != 0) model_r[rd] = data;
        tick();
        bus.rdWrite = 1'b0;
    endtask

    task automatic mem_txn(input bit wr, input bit rdq, input logic [31:0] addr,
                           input logic [31:0] data, input int hold);
        mem_exp_t e;
        int       idx;
        bit       oob;
        int       lat;
        idx = int'((addr >> 2) % MEM_DEPTH);
`ifdef MEM_BOUNDS_CHECK_EN
        oob = (addr >= 32'(4 * MEM_DEPTH));
`else
        oob = 1'b0;
`endif
        if (wr) begin
            if (!oob) begin
                model_m[idx]  = data;
                model_mv[idx] = 1'b1;
            end
            e.is_load = 1'b0;
            e.chk     = 1'b0;
            e.data    = '0;
        end else begin
            e.is_load = 1'b1;
            e.chk     = oob || model_mv[idx];
            e.data    = oob ? 32'h0 : model_m[idx];
        end
        e.err = oob;
        mem_q.push_back(e);
        bus.mem_write   = wr;
        bus.mem_read    = rdq;
        bus.mem_address = addr;
        bus.messReg     = data;
        tick();
        bus.mem_address = $urandom;
        bus.messReg     = $urandom;
        lat = 0;
        while (bus.mem_ack !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        check("mem_ack latency", 32'(lat), 32'(MEM_LATENCY));
        for (int h = 0; h < hold; h++) begin
            tick();
            check("mem_ack held", 32'(bus.mem_ack), 32'h1);
        end
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        tick();
        check("mem_ack drop", 32'(bus.mem_ack), 32'h0);
        check("bus_err drop", 32'(bus.bus_err), 32'h0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] addr_pool [16];
        logic [4:0]  r1, r2, rdx;
        int          kind, ncyc;

        for (int i = 0; i < 32; i++) model_r[i] = '0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            model_m[i]  = '0;
            model_mv[i] = 1'b0;
        end
        for (int i = 0; i < 16; i++) addr_pool[i] = 32'($urandom_range(0, 255)) << 2;

        // Reset: two cycles, then every register reads back as zero.
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        check("reset AmuxIn", bus.AmuxIn, 32'h0);
        check("reset BmuxIn", bus.BmuxIn, 32'h0);
        check("reset data_Ready", 32'(bus.data_Ready), 32'h0);
        check("reset mem_ack", 32'(bus.mem_ack), 32'h0);
        check("reset bus_err", 32'(bus.bus_err), 32'h0);
        reset = 1'b0;
        for (int i = 1; i < 32; i += 2) begin
            op_cycle(5'(i), 5'((i + 1) % 32), 1'b0, 5'd0, 32'h0);
            op_end();
        end

        // Writeback then operand read.
        wb_idle(5'd11, 32'd35);
        op_cycle(5'd11, 5'd0, 1'b0, 5'd0, 32'h0);
        op_end();

        // Same-cycle bypass, and x0 ignores writes.
        op_cycle(5'd3, 5'd12, 1'b1, 5'd12, 32'd4);
        op_end();
        op_cycle(5'd0, 5'd12, 1'b1, 5'd0, 32'hFFFF_FFFF);
        op_end();

        // Held operand request with indices and writes changing each cycle.
        op_cycle(5'd11, 5'd12, 1'b1, 5'd7, 32'h1357_9BDF);
        op_cycle(5'd7, 5'd11, 1'b1, 5'd11, 32'h2468_ACE0);
        op_cycle(5'd11, 5'd7, 1'b0, 5'd0, 32'h0);
        op_end();

        // Store / load / simultaneous read+write.
        mem_txn(1'b1, 1'b0, 32'h48, 32'hA2C0_80A5, 2);
        mem_txn(1'b0, 1'b1, 32'h48, 32'h0, 0);
        mem_txn(1'b1, 1'b1, 32'h48, 32'h5A5A_0001, 1);
        mem_txn(1'b0, 1'b1, 32'h48, 32'h0, 1);

        // Abort: reset lands on the edge that would complete the store.
        mem_txn(1'b1, 1'b0, 32'h10, 32'hCAFE_0010, 0);
        bus.mem_write   = 1'b1;
        bus.mem_address = 32'h10;
        bus.messReg     = 32'h1234;
        tick();
        tick();
        check("abort no ack in wait", 32'(bus.mem_ack), 32'h0);
        reset = 1'b1;
        tick();
        check("abort no ack at reset", 32'(bus.mem_ack), 32'h0);
        bus.mem_write = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 32; i++) model_r[i] = '0;
        tick();
        check("abort idle ack", 32'(bus.mem_ack), 32'h0);
        mem_txn(1'b0, 1'b1, 32'h10, 32'h0, 0);
        op_cycle(5'd11, 5'd12, 1'b0, 5'd0, 32'h0);
        op_end();

        // Bounds: 0x400 is one past the end of a 256-word memory.
        mem_txn(1'b1, 1'b0, 32'h0, 32'hC0FF_EE00, 0);
        mem_txn(1'b0, 1'b1, 32'h400, 32'h0, 0);
        mem_txn(1'b1, 1'b0, 32'h404, 32'h0BAD_0404, 0);
        mem_txn(1'b0, 1'b1, 32'h4, 32'h0, 0);

        // Randomized mix.
        for (int t = 0; t < 200; t++) begin
            kind = $urandom_range(0, 9);
            if (kind < 4) begin
                ncyc = $urandom_range(1, 3);
                for (int c = 0; c < ncyc; c++) begin
                    r1  = 5'($urandom_range(0, 31));
                    r2  = 5'($urandom_range(0, 31));
                    rdx = ($urandom_range(0, 2) == 0) ? r1 : 5'($urandom_range(0, 31));
                    op_cycle(r1, r2, 1'($urandom_range(0, 1)), rdx, $urandom);
                end
                op_end();
            end else if (kind < 5) begin
                wb_idle(5'($urandom_range(0, 31)), $urandom);
            end else begin
                logic [31:0] a;
                if ($urandom_range(0, 4) == 0) a = 32'($urandom_range(0, 32'hFFF));
                else a = addr_pool[$urandom_range(0, 15)] | 32'($urandom_range(0, 3));
                case ($urandom_range(0, 2))
                    0:       mem_txn(1'b1, 1'b0, a, $urandom, $urandom_range(0, 2));
                    1:       mem_txn(1'b0, 1'b1, a, 32'h0, $urandom_range(0, 2));
                    default: mem_txn(1'b1, 1'b1, a, $urandom, $urandom_range(0, 2));
                endcase
            end
        end

        tick();
        tick();
        check("operand queue drained", 32'(op_q.size()), 32'h0);
        check("memory queue drained", 32'(mem_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
